ex_mem_skid: RTL and testbench

Receiving end of the EX-stage ALU outputs: captures `result`/`less`/`zero` plus instruction sideband into a 2-entry skid buffer toward MEM, with valid/ready handshake on both sides. Resolves conditional branches from the ALU flags and issues a registered one-cycle redirect to fetch. Sits between the ALU and the MEM stage; `flush` kills everything in flight.

---
 rtl/ex_pkg.sv | 35 +++
 rtl/skid_buffer2.sv | 55 +++++
 rtl/ex_mem_skid.sv | 86 ++++++++
 tb/tb_ex_mem_skid.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: branch condition encodings, buffered entry layout
// and the branch-condition evaluator used by ex_mem_skid.
package ex_pkg;

  localparam int EX_XLEN = 32;
  localparam int EX_RD_W = 5;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef struct packed {
    logic [EX_XLEN-1:0] result;
    logic [EX_RD_W-1:0] rd;
    logic               wen;
  } ex_entry_t;

  // Signedness is already folded into the ALU's less flag, so BLT/BLTU share logic.
  function automatic logic br_taken(input logic [2:0] funct3, input logic less,
                                    input logic zero);
    case (funct3)
      BR_BEQ:  return zero;
      BR_BNE:  return ~zero;
      BR_BLT:  return less;
      BR_BGE:  return ~less;
      BR_BLTU: return less;
      BR_BGEU: return ~less;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Generic two-slot valid/ready skid buffer; i_ready/o_ready depends only on
// registered state, so there is no combinational ready path through the buffer.
module skid_buffer2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_main_v;
  logic [W-1:0] r_main_d;
  logic         r_skid_v;
  logic [W-1:0] r_skid_d;
  logic         w_push;
  logic         w_pop;

  assign o_ready = ~r_skid_v;
  assign o_valid = r_main_v;
  assign o_data  = r_main_d;
  assign w_push  = i_valid & ~r_skid_v & ~i_flush;
  assign w_pop   = r_main_v & i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_v <= 1'b0;
      r_main_d <= '0;
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
    end else if (i_flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (!r_main_v || w_pop) begin
      // Skid full implies o_ready was low, so no push can coincide with the refill.
      if (r_skid_v) begin
        r_main_d <= r_skid_d;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else begin
        r_main_v <= w_push;
        if (w_push) r_main_d <= i_data;
      end
    end else if (w_push) begin
      r_skid_d <= i_data;
      r_skid_v <= 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM skid stage with branch resolution and a registered one-cycle redirect.
// Optional EX operand bypass ports are enabled by defining EX_MEM_FORWARD_EN.
module ex_mem_skid
  import ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_result,
  input  logic            in_less,
  input  logic            in_zero,
  input  logic            in_is_branch,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wen,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef EX_MEM_FORWARD_EN
  ,
  output logic            fwd_valid,
  output logic [RD_W-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_result
`endif
);

  localparam int PW = XLEN + RD_W + 1;

  logic            w_accept;
  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic [PW-1:0]   w_in_data;
  logic [PW-1:0]   w_out_data;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_taken   = in_is_branch & br_taken(in_funct3, in_less, in_zero);
  assign w_target  = in_pc + in_imm;
  assign w_in_data = {in_result, in_rd, in_wen & ~in_is_branch};

  skid_buffer2 #(.W(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in_data),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_out_data)
  );

  assign {out_result, out_rd, out_wen} = w_out_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_accept & w_taken;
      if (w_accept && w_taken) r_redirect_pc <= w_target;
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

`ifdef EX_MEM_FORWARD_EN
  assign fwd_valid  = out_valid & out_wen;
  assign fwd_rd     = out_rd;
  assign fwd_result = out_result;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed self-checking bench for ex_mem_skid with an in-order output scoreboard.
module tb_ex_mem_skid;
  import ex_pkg::*;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_result;
  logic            in_less;
  logic            in_zero;
  logic            in_is_branch;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [RD_W-1:0] in_rd;
  logic            in_wen;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [RD_W-1:0] out_rd;
  logic            out_wen;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
`ifdef EX_MEM_FORWARD_EN
  logic            fwd_valid;
  logic [RD_W-1:0] fwd_rd;
  logic [XLEN-1:0] fwd_result;
`endif

  ex_mem_skid #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_result      (in_result),
    .in_less        (in_less),
    .in_zero        (in_zero),
    .in_is_branch   (in_is_branch),
    .in_funct3      (in_funct3),
    .in_pc          (in_pc),
    .in_imm         (in_imm),
    .in_rd          (in_rd),
    .in_wen         (in_wen),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_rd         (out_rd),
    .out_wen        (out_wen),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef EX_MEM_FORWARD_EN
    ,
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_result     (fwd_result)
`endif
  );

  always #5 clk = ~clk;

  int        n_assert = 0;
  int        n_fail   = 0;
  ex_entry_t sb[$];
  logic [XLEN-1:0] exp_rpc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference branch condition written directly from the funct3 table.
  function automatic logic model_taken(input logic [2:0] f3, input logic less, input logic zero);
    logic t;
    t = 1'b0;
    if (f3 == 3'b000) t = zero;
    if (f3 == 3'b001) t = !zero;
    if (f3 == 3'b100 || f3 == 3'b110) t = less;
    if (f3 == 3'b101 || f3 == 3'b111) t = !less;
    return t;
  endfunction

  // Output side: every transfer out must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        ex_entry_t e;
        e = sb.pop_front();
        chk("sb_result", out_result, e.result);
        chk("sb_rd", 32'(out_rd), 32'(e.rd));
        chk("sb_wen", 32'(out_wen), 32'(e.wen));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks in_ready, records the expected entry if it transfers in, advances one edge.
  task automatic step(input logic exp_ready);
    ex_entry_t e;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    if (in_valid && exp_ready && !flush) begin
      e.result = in_result;
      e.rd     = in_rd;
      e.wen    = in_wen & !in_is_branch;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic set_alu(input logic [31:0] res, input logic [4:0] rd, input logic wen);
    in_valid = 1'b1; in_result = res; in_rd = rd; in_wen = wen;
    in_is_branch = 1'b0; in_funct3 = 3'b000; in_less = 1'b0; in_zero = 1'b0;
    in_pc = '0; in_imm = '0;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic less, input logic zero,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
    in_valid = 1'b1; in_is_branch = 1'b1; in_funct3 = f3; in_less = less; in_zero = zero;
    in_pc = pc; in_imm = imm; in_rd = rd; in_wen = 1'b1; in_result = pc ^ imm;
  endtask

  // Accepted branch (out_ready high): checks the redirect pulse and target.
  task automatic br_step(input logic [2:0] f3, input logic less, input logic zero,
                         input logic [31:0] pc, input logic [31:0] imm);
    logic t;
    set_br(f3, less, zero, pc, imm, 5'd3);
    t = model_taken(f3, less, zero);
    if (t) exp_rpc = pc + imm;
    step(1'b1);
    chk("br_redirect_valid", 32'(redirect_valid), 32'(t));
    chk("br_redirect_pc", redirect_pc, exp_rpc);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_alu('0, '0, 1'b0);
    in_valid = 1'b0;
    exp_rpc = '0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_wen", 32'(out_wen), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef EX_MEM_FORWARD_EN
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // Streaming at full rate with one-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_alu(32'h1000 + 32'(i), 5'(i + 1), 1'b1);
      step(1'b1);
      chk("stream_out_valid", 32'(out_valid), 32'd1);
      chk("stream_latency", out_result, 32'h1000 + 32'(i));
    end
    in_valid = 1'b0;
    step(1'b1);
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Back-pressure fills main then skid; third entry waits.
    out_ready = 1'b0;
    set_alu(32'hA0A0_0001, 5'd10, 1'b1); step(1'b1);
    set_alu(32'hB0B0_0002, 5'd11, 1'b0); step(1'b1);
    set_alu(32'hC0C0_0003, 5'd12, 1'b1); step(1'b0);
    chk("bp_hold_main", out_result, 32'hA0A0_0001);
    step(1'b0);
    chk("bp_still_held", out_result, 32'hA0A0_0001);
    out_ready = 1'b1;
    step(1'b0);
    chk("bp_skid_to_main", out_result, 32'hB0B0_0002);
    step(1'b1);
    chk("bp_third_in", out_result, 32'hC0C0_0003);
    in_valid = 1'b0;
    step(1'b1);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Directed branches.
    br_step(3'b100, 1'b1, 1'b0, 32'h0000_0100, 32'hFFFF_FFF0);
    chk("blt_target", redirect_pc, 32'h0000_00F0);
    chk("blt_out_wen", 32'(out_wen), 32'd0);
    in_valid = 1'b0; step(1'b1);
    chk("redirect_one_cycle", 32'(redirect_valid), 32'd0);
    chk("redirect_pc_hold", redirect_pc, 32'h0000_00F0);
    br_step(3'b100, 1'b0, 1'b0, 32'h0000_0100, 32'hFFFF_FFF0);
    br_step(3'b111, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0008);
    chk("bgeu_wrap", redirect_pc, 32'h0000_0004);
    br_step(3'b010, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_0040);
    br_step(3'b011, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_0040);

    // Every condition against every flag combination.
    for (int f = 0; f < 8; f++) begin
      for (int fl = 0; fl < 4; fl++) begin
        br_step(3'(f), fl[0], fl[1], $urandom, $urandom);
      end
    end
    in_valid = 1'b0; step(1'b1);

    // Flush with both slots full and a taken branch presented.
    out_ready = 1'b0;
    set_alu(32'h1111_1111, 5'd1, 1'b1); step(1'b1);
    set_alu(32'h2222_2222, 5'd2, 1'b1); step(1'b1);
    set_br(3'b000, 1'b0, 1'b1, 32'h0000_4000, 32'h0000_0010, 5'd4);
    flush = 1'b1;
    step(1'b0);
    sb.delete();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_no_redirect", 32'(redirect_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);

    // Flush while empty: taken branch is not accepted.
    set_br(3'b001, 1'b0, 1'b0, 32'h0000_5000, 32'h0000_0020, 5'd5);
    flush = 1'b1;
    step(1'b1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_empty_valid", 32'(out_valid), 32'd0);
    chk("flush_empty_redirect", 32'(redirect_valid), 32'd0);

    // An already-registered redirect survives a flush in its own cycle.
    set_br(3'b001, 1'b0, 1'b0, 32'h0000_6000, 32'h0000_0030, 5'd6);
    step(1'b1);
    in_valid = 1'b0; flush = 1'b1;
    chk("redirect_before_flush", 32'(redirect_valid), 32'd1);
    chk("redirect_pc_before_flush", redirect_pc, 32'h0000_6030);
    step(1'b1);
    sb.delete();
    flush = 1'b0;
    chk("redirect_after_flush", 32'(redirect_valid), 32'd0);
    chk("out_after_flush", 32'(out_valid), 32'd0);

`ifdef EX_MEM_FORWARD_EN
    out_ready = 1'b0;
    set_alu(32'hDEAD_BEEF, 5'd7, 1'b1); step(1'b1);
    in_valid = 1'b0;
    chk("fwd_valid", 32'(fwd_valid), 32'd1);
    chk("fwd_rd", 32'(fwd_rd), 32'd7);
    chk("fwd_result", fwd_result, 32'hDEAD_BEEF);
    out_ready = 1'b1; step(1'b1);
    set_br(3'b010, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 5'd9);
    out_ready = 1'b0; step(1'b1);
    in_valid = 1'b0;
    chk("fwd_branch_invalid", 32'(fwd_valid), 32'd0);
`endif

    out_ready = 1'b1;
    in_valid  = 1'b0;
    step(1'b1);
    step(1'b1);
    chk("sb_empty_at_end", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
